// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
//   Bundle between the multi-cycle controller and the RV32I-subset datapath.
//
//   Datapath -> controller:
//     run            FSM advance enable (0 freezes the controller)
//     instr[31:0]    instruction register contents
//     cmp_true       ALU compare result (consumed by the datapath PC gating)
//     mem_ready      memory access complete this cycle
//
//   Controller -> datapath:
//     pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write
//     memto_reg[1:0] write-back source  (0 ALUOut, 1 MDR, 2 PC)
//     alu_src_a[1:0] ALU A select       (0 PC, 1 rs1, 2 oldPC)
//     alu_src_b[1:0] ALU B select       (0 rs2, 1 const 4, 2 imm)
//     alu_op[1:0]    (0 pass, 1 CMP, 2 ZERO_OUT, 3 PLUS)
//     cmp_func       (0 equal, 1 unsigned >=)
//     pc_src         (0 ALU result, 1 ALUOut)
//     state[2:0]     current FSM state, debug only
//     halted, illegal, bus_err  sticky status
//
//   Modports: master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface multicycle_control_if;
  logic        run;
  logic [31:0] instr;
  logic        cmp_true;
  logic        mem_ready;

  logic        pc_write;
  logic        pc_write_cond;
  logic        ir_write;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  memto_reg;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        cmp_func;
  logic        pc_src;
  logic [2:0]  state;
  logic        halted;
  logic        illegal;
  logic        bus_err;

  modport master (
    input  run, instr, cmp_true, mem_ready,
    output pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
           reg_write, memto_reg, alu_src_a, alu_src_b, alu_op, cmp_func,
           pc_src, state, halted, illegal, bus_err
  );

  modport slave (
    output run, instr, cmp_true, mem_ready,
    input  pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
           reg_write, memto_reg, alu_src_a, alu_src_b, alu_op, cmp_func,
           pc_src, state, halted, illegal, bus_err
  );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle control FSM for an RV32I-subset datapath (add, addi, lw, sw,
//   beq/bgeu, jal). One shared ALU and one memory port; memory accesses wait
//   on mem_ready with a bounded wait counter. Illegal opcodes or a memory
//   timeout park the FSM in HALT until reset.
//
//   Ports:
//     clk   rising-edge clock
//     rstn  asynchronous active-low reset
//     bus   multicycle_control_if.master (datapath handshake and controls)
//
//   Parameters:
//     TIMEOUT  wait cycles allowed for mem_ready before a bus error
//     CNT_W    wait counter width
//
//   Build option:
//     CTRL_JALR_EN  when defined, jalr (opcode 1100111, funct3 000) is legal;
//                   otherwise that opcode halts the core as illegal.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | 0, all enables off, waits for run
//   FETCH | 1, read instruction at PC, PC+4 computed in parallel
//   DECODE| 2, legality check, branch/jump target into ALUOut
//   EXEC  | 3, per-opcode ALU work, branch/jump resolve
//   MEM   | 4, data load/store through the shared memory port
//   WB    | 5, register file write-back
//   HALT  | 7, parked after illegal opcode or bus timeout
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  multicycle_control_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Last count value before the limit; a wait in this cycle is the TIMEOUT-th.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_alu, is_imm, is_load, is_store, is_branch, is_jal, is_jalr;
  logic       branch_ok, op_legal;
  logic       mem_wait, timeout;

  // Raw enables before run gating.
  logic pc_write_r, pc_write_cond_r, ir_write_r, mem_write_r, reg_write_r;
  logic iord_r, mem_read_r;
  logic [1:0] memto_reg_r, alu_src_a_r, alu_src_b_r, alu_op_r;
  logic cmp_func_r, pc_src_r;

  // Instruction fields and the branch compare result are consumed by the
  // datapath, not by this controller.
  logic unused_bits;
  assign unused_bits = ^{bus.cmp_true, bus.instr[31:15], bus.instr[11:7]};

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];

  assign is_alu    = (opcode == OP_ALU);
  assign is_imm    = (opcode == OP_IMM);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);

`ifdef CTRL_JALR_EN
  localparam logic [6:0] OP_JALR = 7'b1100111;
  assign is_jalr = (opcode == OP_JALR) && (funct3 == 3'b000);
`else
  assign is_jalr = 1'b0;
`endif

  // Only beq (000) and bgeu (111) compares exist in this datapath.
  assign branch_ok = is_branch && ((funct3 == 3'b000) || (funct3 == 3'b111));
  assign op_legal  = is_alu || is_imm || is_load || is_store || branch_ok ||
                     is_jal || is_jalr;

  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) &&
                    bus.run && !bus.mem_ready;
  // mem_ready in the limit cycle is not a wait, so the access wins.
  assign timeout  = mem_wait && (wait_cnt_q == WAIT_LAST);

  // ---------------------------------------------------------------------------
  // Next state and sticky flags
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    if (bus.run) begin
      case (state_q)
        S_IDLE:   state_d = S_FETCH;
        S_FETCH: begin
          if (bus.mem_ready) begin
            state_d = S_DECODE;
          end else if (timeout) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
          end
        end
        S_DECODE: begin
          if (op_legal) begin
            state_d = S_EXEC;
          end else begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        end
        S_EXEC: begin
          if (is_load || is_store)   state_d = S_MEM;
          else if (is_alu || is_imm) state_d = S_WB;
          else                       state_d = S_FETCH;
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            state_d = is_load ? S_WB : S_FETCH;
          end else if (timeout) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
          end
        end
        S_WB:     state_d = S_FETCH;
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_HALT;
      endcase
    end
  end

  // Any state change clears the counter, which covers entry to FETCH and MEM.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_wait) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath controls, combinational from state and instruction
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write_r      = 1'b0;
    pc_write_cond_r = 1'b0;
    ir_write_r      = 1'b0;
    mem_write_r     = 1'b0;
    reg_write_r     = 1'b0;
    iord_r          = 1'b0;
    mem_read_r      = 1'b0;
    memto_reg_r     = 2'd0;
    alu_src_a_r     = 2'd0;
    alu_src_b_r     = 2'd0;
    alu_op_r        = 2'd0;
    cmp_func_r      = 1'b0;
    pc_src_r        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_r  = 1'b1;
        alu_src_b_r = 2'd1;
        alu_op_r    = 2'd3;
        ir_write_r  = bus.mem_ready;
        pc_write_r  = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a_r = 2'd2;
        alu_src_b_r = 2'd2;
        alu_op_r    = 2'd3;
      end
      S_EXEC: begin
        if (is_load || is_store || is_imm) begin
          alu_src_a_r = 2'd1;
          alu_src_b_r = 2'd2;
          alu_op_r    = 2'd3;
        end else if (is_alu) begin
          alu_src_a_r = 2'd1;
          alu_src_b_r = 2'd0;
          alu_op_r    = 2'd3;
        end else if (is_branch) begin
          alu_src_a_r     = 2'd1;
          alu_src_b_r     = 2'd0;
          alu_op_r        = 2'd1;
          cmp_func_r      = bus.instr[14];
          pc_write_cond_r = 1'b1;
          pc_src_r        = 1'b1;
        end else if (is_jal) begin
          reg_write_r = 1'b1;
          memto_reg_r = 2'd2;
          pc_write_r  = 1'b1;
          pc_src_r    = 1'b1;
          alu_op_r    = 2'd2;
        end else if (is_jalr) begin
          // Target is rs1+imm straight from the ALU; datapath clears bit 0.
          alu_src_a_r = 2'd1;
          alu_src_b_r = 2'd2;
          alu_op_r    = 2'd3;
          reg_write_r = 1'b1;
          memto_reg_r = 2'd2;
          pc_write_r  = 1'b1;
          pc_src_r    = 1'b0;
        end
      end
      S_MEM: begin
        iord_r      = 1'b1;
        mem_read_r  = is_load;
        mem_write_r = is_store;
      end
      S_WB: begin
        reg_write_r = 1'b1;
        memto_reg_r = is_load ? 2'd1 : 2'd0;
      end
      default: ;
    endcase
  end

  // Freezing the FSM must also suppress every architectural write.
  assign bus.pc_write      = pc_write_r      & bus.run;
  assign bus.pc_write_cond = pc_write_cond_r & bus.run;
  assign bus.ir_write      = ir_write_r      & bus.run;
  assign bus.mem_write     = mem_write_r     & bus.run;
  assign bus.reg_write     = reg_write_r     & bus.run;
  assign bus.iord          = iord_r;
  assign bus.mem_read      = mem_read_r;
  assign bus.memto_reg     = memto_reg_r;
  assign bus.alu_src_a     = alu_src_a_r;
  assign bus.alu_src_b     = alu_src_b_r;
  assign bus.alu_op        = alu_op_r;
  assign bus.cmp_func      = cmp_func_r;
  assign bus.pc_src        = pc_src_r;
  assign bus.state         = state_q;
  assign bus.halted        = (state_q == S_HALT);
  assign bus.illegal       = illegal_q;
  assign bus.bus_err       = bus_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  // Expected-vector layout (23 bits):
  //   [22:20] state
  //   [19:13] pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write
  //   [12:3]  memto_reg[1:0], alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0], cmp_func, pc_src
  //   [2:0]   halted, illegal, bus_err
  localparam logic [22:0] E_IDLE     = {3'd0, 7'b0000000, 10'b00_00_00_00_0_0, 3'b000};
  localparam logic [22:0] E_F_WAIT   = {3'd1, 7'b0000100, 10'b00_00_01_11_0_0, 3'b000};
  localparam logic [22:0] E_F_RDY    = {3'd1, 7'b1010100, 10'b00_00_01_11_0_0, 3'b000};
  localparam logic [22:0] E_DEC      = {3'd2, 7'b0000000, 10'b00_10_10_11_0_0, 3'b000};
  localparam logic [22:0] E_EX_IMM   = {3'd3, 7'b0000000, 10'b00_01_10_11_0_0, 3'b000};
  localparam logic [22:0] E_EX_ADD   = {3'd3, 7'b0000000, 10'b00_01_00_11_0_0, 3'b000};
  localparam logic [22:0] E_EX_BEQ   = {3'd3, 7'b0100000, 10'b00_01_00_01_0_1, 3'b000};
  localparam logic [22:0] E_EX_BGEU  = {3'd3, 7'b0100000, 10'b00_01_00_01_1_1, 3'b000};
  localparam logic [22:0] E_EX_JAL   = {3'd3, 7'b1000001, 10'b10_00_00_10_0_1, 3'b000};
`ifdef CTRL_JALR_EN
  localparam logic [22:0] E_EX_JALR  = {3'd3, 7'b1000001, 10'b10_01_10_11_0_0, 3'b000};
`endif
  localparam logic [22:0] E_MEM_LW   = {3'd4, 7'b0001100, 10'b00_00_00_00_0_0, 3'b000};
  localparam logic [22:0] E_MEM_SW   = {3'd4, 7'b0001010, 10'b00_00_00_00_0_0, 3'b000};
  localparam logic [22:0] E_WB_ALU   = {3'd5, 7'b0000001, 10'b00_00_00_00_0_0, 3'b000};
  localparam logic [22:0] E_WB_LW    = {3'd5, 7'b0000001, 10'b01_00_00_00_0_0, 3'b000};
  localparam logic [22:0] E_WB_HOLD  = {3'd5, 7'b0000000, 10'b00_00_00_00_0_0, 3'b000};
  localparam logic [22:0] E_HALT_ILL = {3'd7, 7'b0000000, 10'b00_00_00_00_0_0, 3'b110};
  localparam logic [22:0] E_HALT_BUS = {3'd7, 7'b0000000, 10'b00_00_00_00_0_0, 3'b101};

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BGEU = 32'h0020F463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_JALR = 32'h000080E7;

  typedef struct {
    logic [22:0] vec;
    string       name;
  } exp_t;

  logic clk;
  logic rstn;
  exp_t sb_q[$];
  exp_t item;
  logic [22:0] got;
  int n_chk;
  int n_pass;

  multicycle_control_if bus ();

  multicycle_control #(.TIMEOUT(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the DUT must show in that cycle.
  task automatic step(input logic r, input logic [31:0] ins, input logic rdy,
                      input logic [22:0] e, input string nm);
    exp_t t;
    bus.run       = r;
    bus.instr     = ins;
    bus.mem_ready = rdy;
    bus.cmp_true  = 1'($urandom_range(0, 1));
    t.vec  = e;
    t.name = nm;
    sb_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the controller presents a full control word every cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      item = sb_q.pop_front();
      got = {bus.state, bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.iord,
             bus.mem_read, bus.mem_write, bus.reg_write, bus.memto_reg,
             bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.cmp_func, bus.pc_src,
             bus.halted, bus.illegal, bus.bus_err};
      n_chk++;
      if (got === item.vec) n_pass++;
      else $display("FAIL %s: got %06h (state %0d) expected %06h (state %0d)",
                    item.name, got, got[22:20], item.vec, item.vec[22:20]);
    end
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rstn = 1'b0;
    bus.run = 1'b0;
    bus.instr = 32'h0;
    bus.mem_ready = 1'b0;
    bus.cmp_true = 1'b0;
    @(posedge clk);
    #1;

    step(0, I_ADDI, 0, E_IDLE, "reset_idle");
    rstn = 1'b1;
    step(0, I_ADDI, 0, E_IDLE, "idle_no_run");

    // addi: 0,1,2,3,5,1
    step(1, I_ADDI, 1, E_IDLE,   "addi_idle");
    step(1, I_ADDI, 1, E_F_RDY,  "addi_fetch");
    step(1, I_ADDI, 1, E_DEC,    "addi_decode");
    step(1, I_ADDI, 1, E_EX_IMM, "addi_exec");
    step(1, I_ADDI, 1, E_WB_ALU, "addi_wb");

    // lw with three wait cycles in MEM: 8 cycles fetch to fetch
    step(1, I_LW, 1, E_F_RDY,  "lw_fetch");
    step(1, I_LW, 0, E_DEC,    "lw_decode");
    step(1, I_LW, 0, E_EX_IMM, "lw_exec");
    for (int i = 0; i < 3; i++) step(1, I_LW, 0, E_MEM_LW, "lw_mem_wait");
    step(1, I_LW, 1, E_MEM_LW, "lw_mem_ready");
    step(1, I_LW, 0, E_WB_LW,  "lw_wb");

    step(1, I_ADD, 1, E_F_RDY,  "add_fetch");
    step(1, I_ADD, 0, E_DEC,    "add_decode");
    step(1, I_ADD, 0, E_EX_ADD, "add_exec");
    step(1, I_ADD, 0, E_WB_ALU, "add_wb");

    step(1, I_SW, 1, E_F_RDY,  "sw_fetch");
    step(1, I_SW, 0, E_DEC,    "sw_decode");
    step(1, I_SW, 0, E_EX_IMM, "sw_exec");
    step(1, I_SW, 1, E_MEM_SW, "sw_mem");

    step(1, I_BEQ, 1, E_F_RDY,  "beq_fetch");
    step(1, I_BEQ, 1, E_DEC,    "beq_decode");
    step(1, I_BEQ, 1, E_EX_BEQ, "beq_exec");

    step(1, I_BGEU, 1, E_F_RDY,   "bgeu_fetch");
    step(1, I_BGEU, 1, E_DEC,     "bgeu_decode");
    step(1, I_BGEU, 1, E_EX_BGEU, "bgeu_exec");

    step(1, I_JAL, 1, E_F_RDY,  "jal_fetch");
    step(1, I_JAL, 1, E_DEC,    "jal_decode");
    step(1, I_JAL, 1, E_EX_JAL, "jal_exec");

    // run dropped in WB: write held off, then taken on resume
    step(1, I_ADDI, 1, E_F_RDY,   "stall_fetch");
    step(1, I_ADDI, 0, E_DEC,     "stall_decode");
    step(1, I_ADDI, 0, E_EX_IMM,  "stall_exec");
    step(0, I_ADDI, 0, E_WB_HOLD, "stall_wb_frozen1");
    step(0, I_ADDI, 0, E_WB_HOLD, "stall_wb_frozen2");
    step(1, I_ADDI, 0, E_WB_ALU,  "stall_wb_resume");

    // frozen fetch ignores ready; then ready arrives in the limit cycle
    step(0, I_BNE, 1, E_F_WAIT, "fetch_frozen");
    for (int i = 0; i < 3; i++) step(1, I_BNE, 0, E_F_WAIT, "fetch_wait");
    step(1, I_BNE, 1, E_F_RDY,    "fetch_ready_at_limit");
    step(1, I_BNE, 0, E_DEC,      "bne_decode");
    step(1, I_BNE, 0, E_HALT_ILL, "bne_halt");
    step(1, I_BNE, 1, E_HALT_ILL, "bne_halt_sticky");

    rstn = 1'b0;
    step(1, I_BNE, 0, E_IDLE, "reset_after_illegal");
    rstn = 1'b1;

    // fetch timeout after four wait cycles
    step(1, I_ADDI, 0, E_IDLE, "to_idle");
    for (int i = 0; i < 4; i++) step(1, I_ADDI, 0, E_F_WAIT, "to_fetch_wait");
    step(1, I_ADDI, 1, E_HALT_BUS, "to_halt");
    step(1, I_ADDI, 1, E_HALT_BUS, "to_halt_sticky");

    rstn = 1'b0;
    step(1, I_ADDI, 0, E_IDLE, "reset_after_bus_err");
    rstn = 1'b1;

    step(1, I_JALR, 1, E_IDLE,  "jalr_idle");
    step(1, I_JALR, 1, E_F_RDY, "jalr_fetch");
    step(1, I_JALR, 1, E_DEC,   "jalr_decode");
`ifdef CTRL_JALR_EN
    step(1, I_JALR, 1, E_EX_JALR, "jalr_exec");
    step(1, I_JALR, 0, E_F_WAIT,  "jalr_next_fetch");
`else
    step(1, I_JALR, 1, E_HALT_ILL, "jalr_illegal");
`endif

    rstn = 1'b0;
    step(1, I_LW, 0, E_IDLE, "reset_after_jalr");
    rstn = 1'b1;

    // asynchronous reset in the middle of a load
    step(1, I_LW, 1, E_IDLE,   "mid_idle");
    step(1, I_LW, 1, E_F_RDY,  "mid_fetch");
    step(1, I_LW, 0, E_DEC,    "mid_decode");
    step(1, I_LW, 0, E_EX_IMM, "mid_exec");
    step(1, I_LW, 0, E_MEM_LW, "mid_mem");
    rstn = 1'b0;
    step(1, I_LW, 0, E_IDLE, "reset_mid_mem");
    rstn = 1'b1;
    step(0, I_LW, 0, E_IDLE, "idle_after_reset");

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the RV32I-subset datapath: add, addi, lw, sw, beq/bgeu-style compare branch, jal. It replaces the single-cycle decoder. Each instruction is sequenced over 3-5 states, sharing one ALU and one memory port. Memory accesses use a ready handshake with a timeout, and illegal opcodes or bus timeouts halt the core.

## Interface
Parameters:
- `TIMEOUT`, 255 — maximum wait cycles for `mem_ready` before bus error.
- `CNT_W`, `$clog2(TIMEOUT+1)` — width of the wait counter.

Ports:
- `clk` input 1 — the single clock; rising edge.
- `rstn` input 1 — asynchronous, active-low reset.
- `run` input 1 — FSM advance enable; 0 freezes the state.
- `instr` input 32 — instruction register contents, stable from DECODE onward.
- `cmp_true` input 1 — ALU compare result; 1 means the branch is taken.
- `mem_ready` input 1 — memory access complete this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `iord`, `mem_read`, `mem_write`, `reg_write` output 1 each — datapath enables.
- `memto_reg` output 2 — write-back source: 0 ALUOut, 1 MDR, 2 PC.
- `alu_src_a` output 2 — ALU A input: 0 PC, 1 rs1, 2 oldPC.
- `alu_src_b` output 2 — ALU B input: 0 rs2, 1 constant 4, 2 imm.
- `alu_op` output 2 — 0 pass, 1 CMP, 2 ZERO_OUT, 3 PLUS.
- `cmp_func` output 1 — 0 equal, 1 unsigned-greater-or-equal.
- `pc_src` output 1 — 0 ALU result, 1 ALUOut.
- `state` output 3 — current state, for debug.
- `halted`, `illegal`, `bus_err` output 1 each — sticky status flags.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=7.
- Registered: `state`, the wait counter, `illegal`, `bus_err`. All other outputs are combinational from `state`, `instr[6:0]`, `instr[14:12]` and `mem_ready`.
- Any output not listed for a state is 0.
- IDLE: all enables 0. Goes to FETCH when `run`=1.
- FETCH:
  - `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=3.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Goes to DECODE on `mem_ready`.
- DECODE:
  - `alu_src_a`=2, `alu_src_b`=2, `alu_op`=3 (branch/jump target into ALUOut).
  - Goes to EXEC for a legal opcode (0110011, 0010011, 0000011, 0100011, 1100011, 1101111).
  - Any other opcode goes to HALT and sets `illegal`.
  - A branch (1100011) with funct3 other than 000 or 111 is also illegal.
- EXEC by opcode:
  - lw/sw: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=3; then MEM.
  - add: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=3; then WB.
  - addi: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=3; then WB.
  - Branch: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `cmp_func`=`instr[14]`, `pc_write_cond`=1, `pc_src`=1; then FETCH. The PC updates only when `cmp_true`=1; that gating is done in the datapath.
  - jal: `reg_write`=1, `memto_reg`=2, `pc_write`=1, `pc_src`=1, `alu_op`=2; then FETCH.
- MEM:
  - `iord`=1; `mem_read`=1 for lw, `mem_write`=1 for sw.
  - On `mem_ready`: lw goes to WB, sw goes to FETCH.
- WB: `reg_write`=1; `memto_reg`=1 for lw, 0 otherwise; then FETCH.
- HALT: all enables 0, `halted`=1. Leaves HALT only through reset.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle spent in FETCH or MEM with `mem_ready`=0 and `run`=1.
  - When it reaches `TIMEOUT` with `mem_ready`=0, the FSM goes to HALT and sets `bus_err`.
  - `mem_ready`=1 in the same cycle as the timeout wins: the access completes and there is no error.
- `run`=0: state and counter hold, and every write-type enable (`pc_write`, `pc_write_cond`, `ir_write`, `reg_write`, `mem_write`) is forced to 0. `mem_read`, `iord` and the mux selects keep their normal values.

## Timing
- Reset: `state`=IDLE, counter=0, all flags 0, all outputs 0, effective immediately on `rstn` low, with no clock required.
- Reset asserted mid-instruction aborts it and drops all enables combinationally within the same cycle.
- Latency with zero-wait memory (`mem_ready`=1 on first request cycle):
  - lw: 5 cycles.
  - add/addi/sw: 4 cycles.
  - Branch and jal: 3 cycles.
- Each memory wait cycle adds one cycle to FETCH or MEM.
- `mem_ready` is sampled only in FETCH and MEM and is ignored elsewhere.
- Flags are sticky until reset.

## Configuration
- `CTRL_JALR_EN` defined: opcode 1100111 with funct3 000 is legal.
  - EXEC: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=3, `reg_write`=1, `memto_reg`=2, `pc_write`=1, `pc_src`=0; then FETCH.
  - The datapath clears bit 0 of the target.
- `CTRL_JALR_EN` undefined: opcode 1100111 is illegal (DECODE goes to HALT, `illegal`=1).

## Test plan
- Reset, then `run`=1, zero-wait memory, instr=`0x00500093` (addi x1,x0,5) → state sequence 0,1,2,3,5,1; `reg_write`=1 only in WB; `memto_reg`=0.
- lw `0x0000A103` with 3-cycle `mem_ready` delay in MEM → MEM held 3 cycles with `iord`=1, `mem_read`=1; WB `memto_reg`=1; total 8 cycles fetch-to-fetch.
- beq then bgeu funct3 111 → EXEC `alu_op`=1, `cmp_func`=0 then 1, `pc_write_cond`=1, `pc_src`=1; funct3 001 → HALT, `illegal`=1.
- `mem_ready` held 0 in FETCH with `TIMEOUT`=4 → HALT after 4 wait cycles, `bus_err`=1, all enables 0. Repeat with ready on cycle 4 → no error.
- `run` dropped in WB for 2 cycles → `reg_write`=0 and state frozen; write occurs on the first cycle `run` returns to 1.
- Opcode 1100111 → HALT with `illegal`=1 without `CTRL_JALR_EN`; 3-cycle jalr sequence with `pc_src`=0 with it. Assert `rstn` low mid-MEM → outputs 0 immediately, state=IDLE.
